instr_fetch: RTL

- PC-generation and fetch stage. Sits directly upstream of the instruction memory, which has a fixed 1-cycle synchronous read and is word-indexed by addr[31:2].
- Drives the memory address and captures the returned word one cycle later.
- Presents {pc, instruction} to decode through a valid/ready handshake.
- A 2-entry buffer absorbs backpressure, because the memory cannot stall. A redirect input flushes the buffer and restarts fetch at a new PC.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_buf.sv | 82 ++++++++
 rtl/instr_fetch.sv | 118 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
//   Shared constants and types for the instruction fetch stage.
//   - FETCH_ADDR_W / FETCH_DATA_W : PC and instruction widths
//   - DEFAULT_RESET_PC            : PC loaded when reset is asserted
//   - INSTR_STEP                  : byte distance between sequential fetches
//   - fetch_entry_t               : one buffered {pc, instr} pair
//   - align_pc()                  : clears the byte-offset bits of a PC
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [FETCH_ADDR_W-1:0] INSTR_STEP       = 32'd4;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are word aligned; the two low address bits carry no meaning.
    function automatic logic [FETCH_ADDR_W-1:0] align_pc(input logic [FETCH_ADDR_W-1:0] a);
        return {a[FETCH_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
//   Small synchronous FIFO of fetch_entry_t that absorbs decode backpressure.
//   Ports:
//     clk, reset  : rising-edge clock, synchronous active-low reset
//     push        : write wr_entry at the tail this edge
//     pop         : drop the head this edge
//     flush       : discard everything (wins over push and pop)
//     wr_entry    : entry to write
//     head        : current head entry, all zero while empty
//     count       : number of stored entries
//     full, empty : occupancy flags
//   A push and a pop in the same cycle leave count unchanged.
// ---------------------------------------------------------------------------
module fetch_buf
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (reset && !flush && push_ok) begin
            mem_q[wr_q] <= wr_entry;
        end
    end

    assign head = empty ? '0 : mem_q[rd_q];

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   PC generation and fetch stage in front of a 1-cycle synchronous
//   instruction memory. Issues one address per cycle while the output
//   buffer has room, captures the returned word one cycle later and hands
//   {pc, instr} to decode.
//   Ports:
//     clk, reset      : rising-edge clock, synchronous active-low reset
//     mem_addr        : registered fetch address (= pc_q)
//     mem_data        : memory word for the address presented last cycle
//     redirect_valid  : load redirect_pc and flush everything in flight
//     redirect_pc     : redirect target, bits [1:0] ignored
//     out_valid/out_ready/out_instr/out_pc : decode handshake
//   Handshake: an entry transfers on every edge where out_valid and
//   out_ready are both 1; while out_valid is 1 and out_ready is 0 the
//   payload is held stable, and out_valid never depends on out_ready.
//   ADDR_W/DATA_W must match the widths of fetch_entry_t.
// ---------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = FETCH_ADDR_W,
    parameter int                DATA_W    = FETCH_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              inflight_q;

    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    fetch_entry_t      head;
    fetch_entry_t      cap_entry;

    logic              pop;
    logic              issue;
    logic [CNT_W:0]    committed;
    logic [CNT_W:0]    limit;
    logic              redirect_lsbs_unused;

    assign redirect_lsbs_unused = &redirect_pc[1:0];

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;

    // Slots already spoken for are the buffered entries plus the word on
    // its way back from memory. A pop this cycle frees one, so fetch keeps
    // streaming at full rate when decode is draining.
    always_comb begin
        committed = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
        limit     = (CNT_W+1)'(BUF_DEPTH - 1) + {{CNT_W{1'b0}}, pop};
        issue     = !redirect_valid && (committed <= limit);
    end

    // Redirect beats issue; reset beats everything. Clearing inflight_q on
    // redirect drops the word the memory returns for the stale address.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q       <= align_pc(redirect_pc);
            inflight_q <= 1'b0;
        end else if (issue) begin
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
            pc_q          <= pc_q + INSTR_STEP;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    assign mem_addr = pc_q;

    assign cap_entry.pc    = inflight_pc_q;
    assign cap_entry.instr = mem_data;

    fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight_q),
        .pop      (pop),
        .flush    (redirect_valid),
        .wr_entry (cap_entry),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // The issue rule reserves a slot for every outstanding read, so a
    // returning word must always find room.
    push_never_full: assert property (@(posedge clk) disable iff (!reset)
        !(inflight_q && full));

endmodule
